// File: rtl/mux_sel_ctrl.sv
// mux_sel_ctrl: two-source valid/ready front end that drives an enabled 2:1 mux round-robin.
// Optional feature macro MUX_SEL_CTRL_BACK2BACK_EN chains grants with no idle cycle.
module mux_sel_ctrl #(
    parameter int WIDTH       = 4,
    parameter int HOLD_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in0_valid,
    output logic             in0_ready,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in1_valid,
    output logic             in1_ready,
    input  logic [WIDTH-1:0] in1_data,
    output logic             en,
    output logic             sel,
    output logic [WIDTH-1:0] D0,
    output logic [WIDTH-1:0] D1,
    output logic             busy
);

    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_bad_hold
        $fatal(1, "mux_sel_ctrl: HOLD_CYCLES must be in 1..15");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        DRIVE = 1'b1
    } state_e;

    localparam logic [3:0] HoldReload = 4'(HOLD_CYCLES - 1);

    state_e             state_q, state_d;
    logic               en_q, en_d;
    logic               sel_q, sel_d;
    logic               last_q, last_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               full0_q, full0_d;
    logic               full1_q, full1_d;
    logic [WIDTH-1:0]   d0_q, d0_d;
    logic [WIDTH-1:0]   d1_q, d1_d;

    // last resets to 1 so that source 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            en_q    <= 1'b0;
            sel_q   <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= 4'd0;
            full0_q <= 1'b0;
            full1_q <= 1'b0;
            d0_q    <= '0;
            d1_q    <= '0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            full0_q <= full0_d;
            full1_q <= full1_d;
            d0_q    <= d0_d;
            d1_q    <= d1_d;
        end
    end

    always_comb begin
        state_d = state_q;
        en_d    = en_q;
        sel_d   = sel_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        full0_d = full0_q;
        full1_d = full1_q;
        d0_d    = d0_q;
        d1_d    = d1_q;

        case (state_q)
            IDLE: begin
                if (full0_q || full1_q) begin
                    state_d = DRIVE;
                    en_d    = 1'b1;
                    sel_d   = (full0_q && full1_q) ? ~last_q : full1_q;
                    cnt_d   = HoldReload;
                end
            end
            DRIVE: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    last_d = sel_q;
                    if (sel_q) full1_d = 1'b0;
                    else       full0_d = 1'b0;
`ifdef MUX_SEL_CTRL_BACK2BACK_EN
                    // Hand straight over to the other source if it is already waiting.
                    if (sel_q ? full0_q : full1_q) begin
                        sel_d = ~sel_q;
                        cnt_d = HoldReload;
                    end else begin
                        state_d = IDLE;
                        en_d    = 1'b0;
                    end
`else
                    state_d = IDLE;
                    en_d    = 1'b0;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                en_d    = 1'b0;
            end
        endcase

        // A source being freed this edge is still full, so it can never be accepted here too.
        if (in0_valid && !full0_q) begin
            full0_d = 1'b1;
            d0_d    = in0_data;
        end
        if (in1_valid && !full1_q) begin
            full1_d = 1'b1;
            d1_d    = in1_data;
        end
    end

    assign in0_ready = ~full0_q;
    assign in1_ready = ~full1_q;
    assign en        = en_q;
    assign sel       = sel_q;
    assign D0        = d0_q;
    assign D1        = d1_q;
    assign busy      = full0_q | full1_q | en_q;

endmodule

// File: tb/tb_mux_sel_ctrl.sv
// tb_mux_sel_ctrl: directed and randomized checks of mux_sel_ctrl against a grant-level model.
// Honours MUX_SEL_CTRL_BACK2BACK_EN the same way the design does.
module tb_mux_sel_ctrl;

    localparam int W    = 4;
    localparam int HOLD = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         drvValid0, drvValid1;
    logic [W-1:0] drvData0, drvData1;
    logic         in0_ready, in1_ready, en, sel, busy;
    logic [W-1:0] D0, D1;
    logic [W-1:0] yObs;

    int total = 0;
    int bad   = 0;

    // Behavioural model: pending words per source plus the grant currently on the mux.
    bit           mFull [2];
    logic [W-1:0] mData [2];
    bit           mEn;
    bit           mSel;
    bit           mLast;
    int           mHoldLeft;

    mux_sel_ctrl #(.WIDTH(W), .HOLD_CYCLES(HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in0_valid (drvValid0),
        .in0_ready (in0_ready),
        .in0_data  (drvData0),
        .in1_valid (drvValid1),
        .in1_ready (in1_ready),
        .in1_data  (drvData1),
        .en        (en),
        .sel       (sel),
        .D0        (D0),
        .D1        (D1),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // The downstream mux itself.
    assign yObs = en ? (sel ? D1 : D0) : '0;

    task automatic modelReset();
        mFull[0] = 0; mFull[1] = 0;
        mData[0] = '0; mData[1] = '0;
        mEn = 0; mSel = 0; mLast = 1; mHoldLeft = 0;
    endtask

    task automatic modelEdge();
        bit take0, take1;
        take0 = drvValid0 && !mFull[0];
        take1 = drvValid1 && !mFull[1];
        if (mEn) begin
            mHoldLeft--;
            if (mHoldLeft == 0) begin
                mFull[mSel] = 0;
                mLast = mSel;
`ifdef MUX_SEL_CTRL_BACK2BACK_EN
                if (mFull[!mSel]) begin
                    mSel = !mSel;
                    mHoldLeft = HOLD;
                end else begin
                    mEn = 0;
                end
`else
                mEn = 0;
`endif
            end
        end else if (mFull[0] || mFull[1]) begin
            mSel = (mFull[0] && mFull[1]) ? !mLast : mFull[1];
            mEn = 1;
            mHoldLeft = HOLD;
        end
        if (take0) begin mFull[0] = 1; mData[0] = drvData0; end
        if (take1) begin mFull[1] = 1; mData[1] = drvData1; end
    endtask

    task automatic tick();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic doReset();
        drvValid0 = 0; drvValid1 = 0; drvData0 = '0; drvData1 = '0;
        rst_n = 0;
        modelReset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic test_reset();
        drvValid0 = 0; drvValid1 = 0; drvData0 = '0; drvData1 = '0;
        rst_n = 0;
        modelReset();
        #3;
        total++; if (en !== 1'b0) begin bad++; $display("FAIL reset_en got=%b want=0", en); end
        total++; if (sel !== 1'b0) begin bad++; $display("FAIL reset_sel got=%b want=0", sel); end
        total++; if (D0 !== 4'h0) begin bad++; $display("FAIL reset_D0 got=%h want=0", D0); end
        total++; if (D1 !== 4'h0) begin bad++; $display("FAIL reset_D1 got=%h want=0", D1); end
        total++; if (in0_ready !== 1'b1) begin bad++; $display("FAIL reset_rdy0 got=%b want=1", in0_ready); end
        total++; if (in1_ready !== 1'b1) begin bad++; $display("FAIL reset_rdy1 got=%b want=1", in1_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic test_single_word();
        logic       expEn [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [3:0] expY  [4] = '{4'h0, 4'hA, 4'hA, 4'h0};
        logic       expR0 [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        doReset();
        drvValid0 = 1; drvData0 = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 0) drvValid0 = 0;
            total++; if (en !== expEn[i]) begin bad++; $display("FAIL single_en[%0d] got=%b want=%b", i, en, expEn[i]); end
            total++; if (yObs !== expY[i]) begin bad++; $display("FAIL single_y[%0d] got=%h want=%h", i, yObs, expY[i]); end
            total++; if (in0_ready !== expR0[i]) begin bad++; $display("FAIL single_rdy0[%0d] got=%b want=%b", i, in0_ready, expR0[i]); end
            if (expEn[i]) begin
                total++; if (sel !== 1'b0) begin bad++; $display("FAIL single_sel[%0d] got=%b want=0", i, sel); end
            end
        end
    endtask

    task automatic test_tie();
`ifdef MUX_SEL_CTRL_BACK2BACK_EN
        logic       expEn [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic       expSel[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [3:0] expY  [6] = '{4'hA, 4'hA, 4'h2, 4'h2, 4'h0, 4'h0};
`else
        logic       expEn [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic       expSel[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [3:0] expY  [6] = '{4'hA, 4'hA, 4'h0, 4'h2, 4'h2, 4'h0};
`endif
        doReset();
        drvValid0 = 1; drvData0 = 4'b1010;
        drvValid1 = 1; drvData1 = 4'b0010;
        tick();
        drvValid0 = 0; drvValid1 = 0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL tie_busy got=%b want=1", busy); end
        for (int i = 0; i < 6; i++) begin
            tick();
            total++; if (en !== expEn[i]) begin bad++; $display("FAIL tie_en[%0d] got=%b want=%b", i, en, expEn[i]); end
            total++; if (yObs !== expY[i]) begin bad++; $display("FAIL tie_y[%0d] got=%h want=%h", i, yObs, expY[i]); end
            if (expEn[i]) begin
                total++; if (sel !== expSel[i]) begin bad++; $display("FAIL tie_sel[%0d] got=%b want=%b", i, sel, expSel[i]); end
            end
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL tie_idle_busy got=%b want=0", busy); end
    endtask

    task automatic test_fairness();
        logic [W-1:0] words [2][$];
        int           grants = 0;
        int           lastGrant = -1;
        bit           prevEn = 0;
        bit           prevSel = 0;
        bit           take0, take1;
        logic [W-1:0] want;
        doReset();
        drvValid0 = 1; drvData0 = W'($urandom);
        drvValid1 = 1; drvData1 = W'($urandom);
        for (int cyc = 0; cyc < 100 && grants < 8; cyc++) begin
            take0 = !mFull[0];
            take1 = !mFull[1];
            if (take0) words[0].push_back(drvData0);
            if (take1) words[1].push_back(drvData1);
            tick();
            if (take0) drvData0 = W'($urandom);
            if (take1) drvData1 = W'($urandom);
            if (en && (!prevEn || sel != prevSel)) begin
                grants++;
                total++;
                if (lastGrant >= 0 && int'(sel) == lastGrant) begin
                    bad++; $display("FAIL fair_alternate grant=%0d got sel=%b want sel=%b", grants, sel, !sel);
                end
                want = (words[sel].size() > 0) ? words[sel].pop_front() : 'x;
                total++; if (yObs !== want) begin bad++; $display("FAIL fair_word grant=%0d got=%h want=%h", grants, yObs, want); end
                lastGrant = int'(sel);
            end
            prevEn = en; prevSel = sel;
        end
        total++; if (grants < 8) begin bad++; $display("FAIL fair_timeout got=%0d grants want=8", grants); end
        drvValid0 = 0; drvValid1 = 0;
    endtask

    task automatic test_backpressure();
        logic       expEn [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic       expR1 [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [3:0] expD1 [5] = '{4'h6, 4'h6, 4'h6, 4'h6, 4'h9};
        doReset();
        drvValid1 = 1; drvData1 = 4'h6;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 0) drvData1 = 4'h9;
            if (i == 4) drvValid1 = 0;
            total++; if (en !== expEn[i]) begin bad++; $display("FAIL bp_en[%0d] got=%b want=%b", i, en, expEn[i]); end
            total++; if (in1_ready !== expR1[i]) begin bad++; $display("FAIL bp_rdy1[%0d] got=%b want=%b", i, in1_ready, expR1[i]); end
            total++; if (D1 !== expD1[i]) begin bad++; $display("FAIL bp_D1[%0d] got=%h want=%h", i, D1, expD1[i]); end
        end
    endtask

    task automatic test_mid_reset();
        doReset();
        drvValid0 = 1; drvData0 = 4'h5;
        drvValid1 = 1; drvData1 = 4'hC;
        tick();
        drvValid0 = 0; drvValid1 = 0;
        tick();
        tick();
        total++; if (en !== 1'b1) begin bad++; $display("FAIL midrst_pre_en got=%b want=1", en); end
        #2 rst_n = 0;
        modelReset();
        #1;
        total++; if (en !== 1'b0) begin bad++; $display("FAIL midrst_en got=%b want=0", en); end
        total++; if (in0_ready !== 1'b1) begin bad++; $display("FAIL midrst_rdy0 got=%b want=1", in0_ready); end
        total++; if (in1_ready !== 1'b1) begin bad++; $display("FAIL midrst_rdy1 got=%b want=1", in1_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
        @(posedge clk);
        #1 rst_n = 1;
        tick();
        total++; if (en !== 1'b0) begin bad++; $display("FAIL midrst_after_en got=%b want=0", en); end
    endtask

    task automatic test_random();
        bit           take0, take1;
        logic [4+3*W-1:0] obs, exp;
        logic [W-1:0] expY;
        doReset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            take0 = drvValid0 && !mFull[0];
            take1 = drvValid1 && !mFull[1];
            tick();
            expY = mEn ? mData[mSel] : '0;
            obs = {en, in0_ready, in1_ready, busy, D0, D1, yObs};
            exp = {mEn, !mFull[0], !mFull[1], (mFull[0] || mFull[1] || mEn), mData[0], mData[1], expY};
            total++; if (obs !== exp) begin bad++; $display("FAIL rand_outputs cyc=%0d got=%h want=%h", cyc, obs, exp); end
            if (mEn) begin
                total++; if (sel !== mSel) begin bad++; $display("FAIL rand_sel cyc=%0d got=%b want=%b", cyc, sel, mSel); end
            end
            if (take0) begin
                drvValid0 = $urandom_range(1, 0) == 1;
                drvData0 = W'($urandom);
            end else if (!drvValid0 && $urandom_range(2, 0) == 0) begin
                drvValid0 = 1;
                drvData0 = W'($urandom);
            end
            if (take1) begin
                drvValid1 = $urandom_range(1, 0) == 1;
                drvData1 = W'($urandom);
            end else if (!drvValid1 && $urandom_range(2, 0) == 0) begin
                drvValid1 = 1;
                drvData1 = W'($urandom);
            end
        end
        drvValid0 = 0; drvValid1 = 0;
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_tie();
        test_fairness();
        test_backpressure();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
